// File: rtl/seq_event_monitor.sv
// Purpose: turns the 11011 detector output level into counted events, measuring
//          last/min spacing between events and raising a sticky alarm at THRESH events.
// Latency: one cycle from a det_in rise to event_pulse and updated stats; no backpressure.
// Ports: clk/rst (async active-high), det_in (detector level), clr (sync clear);
//        event_pulse, event_cnt, last_gap, min_gap, alarm, state_o (all registered).
module seq_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  output logic             event_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic [GAP_W-1:0] min_gap,
  output logic             alarm,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_ALARM = 2'b10;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [1:0]       state_q, state_d;
  logic             det_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] last_gap_q;
  logic [GAP_W-1:0] min_gap_q;
  logic             alarm_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap_inc;
  logic [GAP_W-1:0] gap_min;

  assign rise    = det_in & ~det_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign gap_inc = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
  assign gap_min = (gap_cnt_q < min_gap_q) ? gap_cnt_q : min_gap_q;

  // det_q follows det_in even during clr, so a level present at clear time
  // is never counted later as a fresh rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_q <= 1'b0;
    end else begin
      det_q <= det_in;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (rise) state_d = (THRESH == 1) ? ST_ALARM : ST_TRACK;
        ST_TRACK: if (rise && (cnt_inc >= THRESH_C)) state_d = ST_ALARM;
        ST_ALARM: state_d = ST_ALARM;
        default:  state_d = ST_IDLE;  // unreachable 2'b11 recovers
      endcase
    end
  end

  // FSM: Moore output
  always_comb begin
    alarm_d = (state_q == ST_ALARM);
  end

  // Event counting and gap measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
      gap_cnt_q  <= '0;
      last_gap_q <= '0;
      min_gap_q  <= '1;
    end else if (clr) begin
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
      gap_cnt_q  <= '0;
      last_gap_q <= '0;
      min_gap_q  <= '1;
    end else begin
      pulse_q   <= rise;
      gap_cnt_q <= rise ? GAP_W'(1) : gap_inc;
      if (rise) begin
        case (state_q)
          // First event has no predecessor, so gaps are left untouched.
          ST_IDLE: cnt_q <= CNT_W'(1);
          ST_TRACK, ST_ALARM: begin
            cnt_q      <= cnt_inc;
            last_gap_q <= gap_cnt_q;
            min_gap_q  <= gap_min;
          end
          default: ;
        endcase
      end
    end
  end

  assign event_pulse = pulse_q;
  assign event_cnt   = cnt_q;
  assign last_gap    = last_gap_q;
  assign min_gap     = min_gap_q;
  assign alarm       = alarm_d;
  assign state_o     = state_q;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Purpose: directed self-checking bench for seq_event_monitor (default and CNT_W=3 instances).
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none in the design; stimulus is free-running.
module tb_seq_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       det_in;
  logic       clr;

  logic       event_pulse;
  logic [7:0] event_cnt;
  logic [7:0] last_gap;
  logic [7:0] min_gap;
  logic       alarm;
  logic [1:0] state_o;

  logic       s_event_pulse;
  logic [2:0] s_event_cnt;
  logic [7:0] s_last_gap;
  logic [7:0] s_min_gap;
  logic       s_alarm;
  logic [1:0] s_state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_event_monitor #(.CNT_W(8), .GAP_W(8), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .event_pulse(event_pulse), .event_cnt(event_cnt), .last_gap(last_gap),
    .min_gap(min_gap), .alarm(alarm), .state_o(state_o)
  );

  seq_event_monitor #(.CNT_W(3), .GAP_W(8), .THRESH(4)) dut_small (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .event_pulse(s_event_pulse), .event_cnt(s_event_cnt), .last_gap(s_last_gap),
    .min_gap(s_min_gap), .alarm(s_alarm), .state_o(s_state_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    det_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle detector hit; returns with the post-rise outputs visible.
  task automatic hit();
    det_in = 1'b1;
    tick();
    det_in = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; det_in = 1'b0; clr = 1'b0;

    // 1. Reset values, then idle with det_in low
    tick(); tick();
    check("rst_pulse", event_pulse, 0);
    check("rst_cnt",   event_cnt,   0);
    check("rst_last",  last_gap,    0);
    check("rst_min",   min_gap,     255);
    check("rst_alarm", alarm,       0);
    check("rst_state", state_o,     0);
    rst = 1'b0;
    run(20);
    check("idle_cnt",   event_cnt, 0);
    check("idle_min",   min_gap,   255);
    check("idle_state", state_o,   0);
    check("idle_pulse", event_pulse, 0);

    // 2. Threshold: four hits 5 cycles apart
    run(9);
    hit();
    check("thr_pulse1", event_pulse, 1);
    check("thr_cnt1",   event_cnt,   1);
    check("thr_state1", state_o,     1);
    check("thr_last1",  last_gap,    0);
    tick();
    check("thr_pulse_off", event_pulse, 0);
    for (int i = 2; i <= 4; i++) begin
      run(3);
      if (i == 4) check("thr_alarm_pre", alarm, 0);
      hit();
      check("thr_pulse", event_pulse, 1);
      check("thr_cnt",   event_cnt,   i);
      check("thr_last",  last_gap,    5);
      if (i < 4) tick();
    end
    check("thr_min",   min_gap, 5);
    check("thr_alarm", alarm,   1);
    check("thr_state", state_o, 2);

    // 3. Held level counts once
    do_clr();
    check("clr_state", state_o, 0);
    check("clr_alarm", alarm,   0);
    pulses = 0;
    det_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) check("held_first", event_pulse, 1);
      pulses += int'(event_pulse);
    end
    det_in = 1'b0;
    tick();
    pulses += int'(event_pulse);
    check("held_pulses", pulses, 1);
    check("held_cnt", event_cnt, 1);
    run(9);
    hit();
    check("held_gap20", last_gap, 20);
    run(2);
    hit();
    check("held_last", last_gap, 3);
    check("held_min",  min_gap,  3);
    check("held_cnt3", event_cnt, 3);
    check("held_track", state_o, 1);

    // 4. Clear coincident with a rise
    run(2);
    hit();
    check("cr_alarm_set", alarm, 1);
    det_in = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("cr_state", state_o,     0);
    check("cr_cnt",   event_cnt,   0);
    check("cr_pulse", event_pulse, 0);
    check("cr_alarm", alarm,       0);
    check("cr_min",   min_gap,     255);
    tick();
    check("cr_nocount", event_cnt, 0);
    check("cr_nopulse", event_pulse, 0);
    run(1);
    hit();
    check("cr_cnt1",  event_cnt, 1);
    check("cr_track", state_o,   1);
    check("cr_last0", last_gap,  0);

    // 5. Saturation: long gap, then counter wrap on the 3-bit instance
    do_clr();
    hit();
    run(299);
    hit();
    check("sat_gap", last_gap, 255);
    check("sat_min", min_gap,  255);
    do_clr();
    for (int i = 1; i <= 9; i++) begin
      hit();
      check("sat_small_cnt", s_event_cnt, (i > 7) ? 7 : i);
      run(1);
    end
    check("sat_small_alarm", s_alarm,   1);
    check("sat_big_cnt",     event_cnt, 9);
    check("sat_small_min",   s_min_gap, 2);

    // 6. Asynchronous reset mid-cycle while in ALARM
    do_clr();
    for (int i = 0; i < 6; i++) begin
      hit();
      run(1);
    end
    check("ar_pre_cnt",   event_cnt, 6);
    check("ar_pre_alarm", alarm,     1);
    #2 rst = 1'b1;
    #1;
    check("ar_alarm", alarm,     0);
    check("ar_cnt",   event_cnt, 0);
    check("ar_state", state_o,   0);
    check("ar_min",   min_gap,   255);
    #2 rst = 1'b0;
    tick();
    hit();
    check("ar_post_state", state_o,   1);
    check("ar_post_cnt",   event_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_event_monitor.md
# seq_event_monitor

Downstream consumer of the 11011 Moore sequence detector. It takes the detector's `out` level as `det_in` and converts each rising edge into one registered event pulse. It counts events (saturating), measures the cycle spacing between consecutive events (last and minimum gap), and raises a sticky alarm once a programmed event count is reached. Software or a higher-level controller clears the block with a synchronous `clr`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the event counter.
- `GAP_W`, default 8: width of the gap counter and gap outputs.
- `THRESH`, default 4: event count that triggers the alarm. Legal range is 1 to 2^CNT_W-1.

Ports:
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `det_in` input, 1 bit: detector output level, synchronous to `clk`.
- `clr` input, 1 bit: synchronous clear, active-high.
- `event_pulse` output, 1 bit: one-cycle pulse per counted event.
- `event_cnt` output, CNT_W bits: number of events counted, saturating.
- `last_gap` output, GAP_W bits: cycle distance between the two most recent events.
- `min_gap` output, GAP_W bits: smallest gap seen since reset or clear.
- `alarm` output, 1 bit: sticky alarm, high when the state is ALARM.
- `state_o` output, 2 bits: current state. IDLE=00, TRACK=01, ALARM=10.

## Operation
- **Edge detect:** `det_d` registers `det_in` every cycle, including cycles where `clr` is high. `rise = det_in & ~det_d`.
  - A level held high for N cycles produces exactly one rise.
  - `det_d` resets to 0, so `det_in` high at reset release counts as a rise.
- **Event pulse:** `event_pulse <= rise & ~clr`.
- **Gap counter `gap_cnt`** (internal, GAP_W bits):
  - On a rise: load 1.
  - Otherwise: increment, saturating at 2^GAP_W-1.
  - Reset/clear value is 0.
- **FSM** (registered state; `alarm` is a Moore output of state):
  - IDLE:
    - On a rise: `event_cnt` <= 1. `last_gap` and `min_gap` are not updated (no previous event).
    - Next state is ALARM if THRESH==1, else TRACK.
  - TRACK:
    - On a rise: `event_cnt` <= `event_cnt`+1; `last_gap` <= `gap_cnt`; `min_gap` <= min(`min_gap`, `gap_cnt`).
    - Go to ALARM when the new count is >= THRESH.
  - ALARM:
    - Rises are still counted and measured exactly as in TRACK.
    - The state remains ALARM until `clr` or `rst`.
  - Encoding 11 is unreachable and must recover to IDLE on the next edge.
- **Saturation:**
  - `event_cnt` holds at 2^CNT_W-1 on further rises.
  - `gap_cnt` saturates, so a gap longer than 2^GAP_W-1 cycles is reported as 2^GAP_W-1.
- **Clear (`clr`=1 at an edge)** has priority over everything else:
  - state=IDLE, `event_cnt`=0, `last_gap`=0, `min_gap`=all ones, `gap_cnt`=0, `event_pulse`=0.
  - A rise in the same cycle is discarded. Because `det_d` still updates, that level is not recounted afterwards.
- **Reset values:**
  - `event_pulse`=0, `event_cnt`=0, `last_gap`=0, `min_gap`=2^GAP_W-1, `alarm`=0, `state_o`=00.
  - Internal: `det_d`=0, `gap_cnt`=0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: a rise on `det_in` in cycle t gives `event_pulse`=1 in cycle t+1 only. The updated `event_cnt`, `last_gap`, `min_gap` and `state_o` are visible in the same cycle t+1.
- Alarm latency: the rise that brings the count to THRESH in cycle t sets `alarm`=1 from cycle t+1.
- Gap definition: rises in cycles t1 and t2 give `last_gap` = t2-t1, visible in cycle t2+1. Back-to-back non-overlapping detector hits are 5 cycles apart, so they report 5.
- Asynchronous reset mid-operation forces all reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after `rst` deasserts.
- No handshake: the block accepts a rise in every cycle and never back-pressures.

## Test plan
1. **Reset:** assert `rst` with `det_in`=0 → all outputs at their reset values (`min_gap`=255), `state_o`=00. Release `rst` and hold for 20 cycles → outputs unchanged.
2. **Threshold:** THRESH=4, one-cycle `det_in` pulses at cycles 10, 15, 20, 25.
   - `event_pulse` high at cycles 11, 16, 21, 26.
   - `event_cnt`=4, `last_gap`=5, `min_gap`=5.
   - `alarm` rises at cycle 26; `state_o` sequence is 01 at cycle 11, then 10 at cycle 26.
3. **Held level:** `det_in` high for cycles 10-19 → exactly one `event_pulse` at cycle 11, `event_cnt`=1. Pulses at 30 and 33 then give `last_gap`=3 and `min_gap`=3.
4. **Clear with rise:** reach ALARM, then assert `clr` in the same cycle as a rise → next cycle shows IDLE, `event_cnt`=0, `event_pulse`=0, `alarm`=0. The next rise gives `event_cnt`=1 in TRACK with `last_gap` still 0.
5. **Saturation:** GAP_W=8, rises 300 cycles apart → `last_gap`=255. With CNT_W=3, nine rises → `event_cnt` holds at 7 and `alarm` stays 1.
6. **Async reset:** assert `rst` between clock edges while in ALARM with `event_cnt`=6 → `alarm`=0 and `event_cnt`=0 before the next edge. After release, the first rise goes to TRACK.
